// File: rtl/avalon_reg_if.sv
// avalon_reg_if: Avalon-MM slave front end for a byte-enabled register bank.
// Optional write counter read at address NREGS: define AVALON_REG_IF_WRCOUNT_EN.
module avalon_reg_if #(
  parameter int NREGS  = 4,
  parameter int ADDR_W = 3
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  input  logic [3:0]          avs_byteenable,
  output logic [31:0]         avs_readdata,
  output logic                avs_waitrequest,
  output logic [31:0]         reg_D,
  output logic [4*NREGS-1:0]  reg_be,
  input  logic [32*NREGS-1:0] reg_Q
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       sel;

`ifdef AVALON_REG_IF_WRCOUNT_EN
  logic [31:0] wrcnt_q, wrcnt_d;
  logic        in_range;

  assign in_range =
    {1'b0, addr_q} < (ADDR_W+1)'(NREGS);

  // Count writes that actually touch a register byte
  always_comb begin
    wrcnt_d = wrcnt_q;
    if (state_q == WRITE && in_range
        && be_q != 4'b0000)
      wrcnt_d = wrcnt_q + 32'd1;
  end

  // Write counter register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) wrcnt_q <= '0;
    else         wrcnt_q <= wrcnt_d;
  end
`endif

  // Read mux: out-of-range addresses return 0
  always_comb begin
    sel = '0;
    for (int i = 0; i < NREGS; i++)
      if (addr_q == ADDR_W'(i))
        sel = reg_Q[32*i +: 32];
`ifdef AVALON_REG_IF_WRCOUNT_EN
    if (addr_q == ADDR_W'(NREGS))
      sel = wrcnt_q;
`endif
  end

  // Byte enables only to the addressed register, only in WRITE
  always_comb begin
    reg_be = '0;
    if (state_q == WRITE)
      for (int i = 0; i < NREGS; i++)
        if (addr_q == ADDR_W'(i))
          reg_be[4*i +: 4] = be_q;
  end

  // Next-state and capture logic; write wins over read
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (avs_write) begin
          addr_d  = avs_address;
          data_d  = avs_writedata;
          be_d    = avs_byteenable;
          state_d = WRITE;
        end else if (avs_read) begin
          addr_d  = avs_address;
          state_d = READ;
        end
      end
      WRITE: state_d = DONE;
      READ: begin
        rdata_d = sel;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  assign reg_D        = data_q;
  assign avs_readdata = rdata_q;
  assign avs_waitrequest =
    (avs_read | avs_write) & (state_q != DONE);

endmodule

// File: tb/tb_avalon_reg_if.sv
// tb_avalon_reg_if: randomized bench with a register-bank
// environment and a transaction-level reference model.
module tb_avalon_reg_if;

  localparam int NREGS  = 4;
  localparam int ADDR_W = 3;

  logic                clock = 1'b0;
  logic                resetn;
  logic [ADDR_W-1:0]   avs_address;
  logic                avs_read;
  logic                avs_write;
  logic [31:0]         avs_writedata;
  logic [3:0]          avs_byteenable;
  logic [31:0]         avs_readdata;
  logic                avs_waitrequest;
  logic [31:0]         reg_D;
  logic [4*NREGS-1:0]  reg_be;
  logic [32*NREGS-1:0] reg_Q;

  logic [31:0] bank [NREGS];
  logic [31:0] mdl  [NREGS];
  logic [31:0] mcnt;
  int          nvec;
  int          nerr;

  always #5 clock = ~clock;

  avalon_reg_if #(.NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .avs_address    (avs_address),
    .avs_read       (avs_read),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_byteenable (avs_byteenable),
    .avs_readdata   (avs_readdata),
    .avs_waitrequest(avs_waitrequest),
    .reg_D          (reg_D),
    .reg_be         (reg_be),
    .reg_Q          (reg_Q)
  );

  // Downstream register bank
  always_comb
    for (int i = 0; i < NREGS; i++)
      reg_Q[32*i +: 32] = bank[i];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++)
        bank[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        for (int b = 0; b < 4; b++)
          if (reg_be[4*i+b])
            bank[i][8*b +: 8] <= reg_D[8*b +: 8];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(
      input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++)
      m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    mcnt = '0;
  endtask

  task automatic mdl_write(input logic [2:0] a,
                           input logic [31:0] d,
                           input logic [3:0] be);
    logic [31:0] m;
    m = lane_mask(be);
    if (int'(a) < NREGS) begin
      mdl[a] = (mdl[a] & ~m) | (d & m);
      if (be != 4'b0000) mcnt = mcnt + 1;
    end
  endtask

  function automatic logic [31:0] mdl_read(
      input logic [2:0] a);
    if (int'(a) < NREGS) return mdl[a];
`ifdef AVALON_REG_IF_WRCOUNT_EN
    if (int'(a) == NREGS) return mcnt;
`endif
    return 32'h0;
  endfunction

  task automatic bus_write(input logic [2:0] a,
                           input logic [31:0] d,
                           input logic [3:0] be,
                           input logic also_rd);
    int cyc;
    int hits;
    logic [15:0] seen;
    logic [15:0] exp_be;
    exp_be = '0;
    if (int'(a) < NREGS) exp_be[4*a +: 4] = be;
    @(negedge clock);
    avs_address    = a;
    avs_writedata  = d;
    avs_byteenable = be;
    avs_write      = 1'b1;
    avs_read       = also_rd;
    #1;
    chk("wr_wait0", 32'(avs_waitrequest), 32'd1);
    cyc  = 0;
    hits = 0;
    seen = '0;
    while (cyc < 8) begin
      @(negedge clock);
      cyc++;
      if (reg_be != '0) begin
        hits++;
        seen = reg_be;
      end
      if (!avs_waitrequest) break;
    end
    avs_write = 1'b0;
    avs_read  = 1'b0;
    mdl_write(a, d, be);
    chk("wr_lat", cyc, 32'd2);
    chk("wr_be", 32'(seen), 32'(exp_be));
    chk("wr_be_cyc", hits, 32'(exp_be != '0));
    chk("wr_D", reg_D, d);
  endtask

  task automatic bus_read(input logic [2:0] a);
    int cyc;
    @(negedge clock);
    avs_address = a;
    avs_read    = 1'b1;
    #1;
    chk("rd_wait0", 32'(avs_waitrequest), 32'd1);
    cyc = 0;
    while (cyc < 8) begin
      @(negedge clock);
      cyc++;
      chk("rd_be0", 32'(reg_be), 32'd0);
      if (!avs_waitrequest) break;
    end
    avs_read = 1'b0;
    chk("rd_lat", cyc, 32'd2);
    chk("rd_data", avs_readdata, mdl_read(a));
  endtask

  initial begin
    logic [2:0]  ra;
    logic [3:0]  rbe;
    logic [31:0] rd;
    nvec = 0;
    nerr = 0;
    resetn         = 1'b0;
    avs_address    = '0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_writedata  = '0;
    avs_byteenable = '0;
    mdl_reset();
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    chk("rst_rdata", avs_readdata, 32'h0);
    chk("rst_be", 32'(reg_be), 32'h0);
    chk("rst_wait", 32'(avs_waitrequest), 32'h0);
    chk("rst_D", reg_D, 32'h0);
    for (int i = 0; i < NREGS; i++) bus_read(3'(i));

    bus_write(3'd2, 32'hDEADBEEF, 4'hF, 1'b0);
    bus_read(3'd2);
    chk("full_wr", avs_readdata, 32'hDEADBEEF);

    bus_write(3'd1, 32'h11223344, 4'hF, 1'b0);
    bus_write(3'd1, 32'hAABBCCDD, 4'b0101, 1'b0);
    bus_read(3'd1);
    chk("partial", avs_readdata, 32'h11BB33DD);

    bus_write(3'd5, 32'h12345678, 4'hF, 1'b0);
    bus_write(3'd2, 32'h0BADF00D, 4'h0, 1'b0);
    bus_read(3'd2);
    chk("be0_keep", avs_readdata, 32'hDEADBEEF);
    bus_read(3'd5);
    chk("oor_rd", avs_readdata, 32'h0);
    bus_write(3'd0, 32'hCAFEF00D, 4'hF, 1'b1);
    bus_read(3'd0);
    chk("wr_rd_both", avs_readdata, 32'hCAFEF00D);

    for (int n = 0; n < 80; n++) begin
      ra  = 3'($urandom_range(0, 7));
      rd  = $urandom;
      rbe = ($urandom_range(0, 4) == 0) ? 4'h0
            : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) bus_read(ra);
      else bus_write(ra, rd, rbe,
                     1'($urandom_range(0, 1)));
    end

    @(negedge clock);
    avs_address    = 3'd3;
    avs_writedata  = 32'hFFFFFFFF;
    avs_byteenable = 4'hF;
    avs_write      = 1'b1;
    @(negedge clock);
    chk("mw_be_on", 32'(reg_be), 32'h0000F000);
    resetn = 1'b0;
    #1;
    chk("mw_be_off", 32'(reg_be), 32'h0);
    chk("mw_rdata", avs_readdata, 32'h0);
    chk("mw_D", reg_D, 32'h0);
    avs_write = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    mdl_reset();
    for (int i = 0; i < NREGS; i++) begin
      bus_read(3'(i));
      chk("mw_rd0", avs_readdata, 32'h0);
    end

`ifdef AVALON_REG_IF_WRCOUNT_EN
    bus_write(3'd0, 32'h1, 4'hF, 1'b0);
    bus_write(3'd1, 32'h2, 4'h3, 1'b0);
    bus_write(3'd2, 32'h3, 4'h0, 1'b0);
    bus_write(3'd4, 32'h4, 4'hF, 1'b0);
    bus_write(3'd3, 32'h5, 4'h8, 1'b0);
    bus_read(3'd4);
    chk("cnt3", avs_readdata, 32'd3);
    @(negedge clock);
    force dut.wrcnt_q = 32'hFFFFFFFF;
    #1;
    release dut.wrcnt_q;
    mcnt = 32'hFFFFFFFF;
    bus_write(3'd0, 32'h9, 4'hF, 1'b0);
    bus_read(3'd4);
    chk("cnt_wrap", avs_readdata, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
